// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM bus arbiter.
// Optional feature macro: VRAM_ARB_CPU_LOCKOUT_EN (used by vram_bus_arbiter).
package vram_arb_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;

  // Data returned to a locked-out CPU read; also the read-data reset value.
  localparam logic [VRAM_DW-1:0] LOCKOUT_DATA = 8'hFF;
  localparam logic [VRAM_DW-1:0] RDATA_RST    = 8'hFF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Latched transaction presented on the VRAM port.
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] wdata;
    logic               wr;
  } xact_t;

  // Requester bit position (bit0 PPU, bit1 DMA, bit2 CPU) for an owner code.
  function automatic logic [2:0] owner_mask(owner_t o);
    case (o)
      OWN_PPU: return 3'b001;
      OWN_DMA: return 3'b010;
      OWN_CPU: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vram_arb_prio.sv
// Fixed-priority picker: PPU > DMA > CPU, after removing excluded requesters.
// Ports:
//   req_i   [2:0] request vector (bit0 PPU, bit1 DMA, bit2 CPU)
//   excl_i  [2:0] exclude mask, same bit order
//   win_c_o       combinational winner owner code (OWN_NONE if no request)
module vram_arb_prio
  import vram_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] excl_i,
  output owner_t     win_c_o
);

  logic [2:0] elig;

  always_comb begin
    elig    = req_i & ~excl_i;
    win_c_o = OWN_NONE;
    if (elig[0])      win_c_o = OWN_PPU;
    else if (elig[1]) win_c_o = OWN_DMA;
    else if (elig[2]) win_c_o = OWN_CPU;
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the single VRAM port between PPU fetcher, OAM DMA and CPU using
// fixed two-cycle ADDR/DATA transactions, each answered by a one-cycle ack.
// Optional feature macro: VRAM_ARB_CPU_LOCKOUT_EN -- when defined, CPU
// requests during cpu_lockout are acked immediately without a VRAM cycle
// (reads return 8'hFF, writes are dropped).
// Ports:
//   clk1, reset                 clock, synchronous active-high reset
//   {ppu,dma,cpu}_req / _a      requests and 13-bit addresses
//   cpu_wr, cpu_d               CPU write flag and write data
//   cpu_lockout                 PPU mode 3 / DMA-from-VRAM active
//   {ppu,dma,cpu}_ack / _q      completion pulses and held read data
//   ma, md_out, md_in           VRAM address, write data, read data
//   mcs, moe, mwr, md_b         chip select, output enable, write, data drive
//   owner                       current bus owner code
module vram_bus_arbiter
  import vram_arb_pkg::*;
(
  input  logic               clk1,
  input  logic               reset,
  input  logic               ppu_req,
  input  logic               dma_req,
  input  logic               cpu_req,
  input  logic [VRAM_AW-1:0] ppu_a,
  input  logic [VRAM_AW-1:0] dma_a,
  input  logic [VRAM_AW-1:0] cpu_a,
  input  logic               cpu_wr,
  input  logic [VRAM_DW-1:0] cpu_d,
  input  logic               cpu_lockout,
  output logic               ppu_ack,
  output logic               dma_ack,
  output logic               cpu_ack,
  output logic [VRAM_DW-1:0] ppu_q,
  output logic [VRAM_DW-1:0] dma_q,
  output logic [VRAM_DW-1:0] cpu_q,
  output logic [VRAM_AW-1:0] ma,
  output logic [VRAM_DW-1:0] md_out,
  input  logic [VRAM_DW-1:0] md_in,
  output logic               mcs,
  output logic               moe,
  output logic               mwr,
  output logic               md_b,
  output logic [1:0]         owner
);

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  xact_t              xact_q, xact_d;
  logic [2:0]         ack_q, ack_d;
  logic [VRAM_DW-1:0] ppu_rd_q, ppu_rd_d;
  logic [VRAM_DW-1:0] dma_rd_q, dma_rd_d;
  logic [VRAM_DW-1:0] cpu_rd_q, cpu_rd_d;
  logic               mcs_q, mcs_d, moe_q, moe_d, mwr_q, mwr_d, mdb_q, mdb_d;

  logic               cpu_elig;
  logic               lock_ack;
  logic               grant;
  logic [2:0]         excl;
  owner_t             win;

`ifdef VRAM_ARB_CPU_LOCKOUT_EN
  // A locked-out CPU request is answered at once unless it already owns the bus.
  assign cpu_elig = cpu_req & ~cpu_lockout;
  assign lock_ack = cpu_req & cpu_lockout & (owner_q != OWN_CPU) & ~ack_q[2];
`else
  logic unused_lockout;
  assign unused_lockout = cpu_lockout;
  assign cpu_elig       = cpu_req;
  assign lock_ack       = 1'b0;
`endif

  // The owner being served is still requesting on its DATA edge; skip it.
  assign excl = (state_q == ST_DATA) ? owner_mask(owner_q) : 3'b000;

  vram_arb_prio u_prio (
    .req_i   ({cpu_elig, dma_req, ppu_req}),
    .excl_i  (excl),
    .win_c_o (win)
  );

  // Next-state, transaction latch, read capture, acks and strobes.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    xact_d   = xact_q;
    ack_d    = 3'b000;
    ppu_rd_d = ppu_rd_q;
    dma_rd_d = dma_rd_q;
    cpu_rd_d = cpu_rd_q;
    grant    = 1'b0;

    case (state_q)
      ST_IDLE: grant = 1'b1;
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (!xact_q.wr) begin
          case (owner_q)
            OWN_PPU: ppu_rd_d = md_in;
            OWN_DMA: dma_rd_d = md_in;
            OWN_CPU: cpu_rd_d = md_in;
            default: ;
          endcase
        end
        ack_d = owner_mask(owner_q);
        grant = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    if (grant) begin
      if (win != OWN_NONE) begin
        state_d = ST_ADDR;
        owner_d = win;
        case (win)
          OWN_PPU: xact_d.addr = ppu_a;
          OWN_DMA: xact_d.addr = dma_a;
          default: xact_d.addr = cpu_a;
        endcase
        xact_d.wr = (win == OWN_CPU) & cpu_wr;
        if (win == OWN_CPU) xact_d.wdata = cpu_d;
      end else begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    end

    if (lock_ack) begin
      ack_d[2] = 1'b1;
      if (!cpu_wr) cpu_rd_d = LOCKOUT_DATA;
    end

    mcs_d = (state_d != ST_IDLE);
    moe_d = mcs_d & ~xact_d.wr;
    mwr_d = (state_d == ST_DATA) & xact_d.wr;
    mdb_d = mcs_d & xact_d.wr;
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      xact_q   <= '0;
      ack_q    <= 3'b000;
      ppu_rd_q <= RDATA_RST;
      dma_rd_q <= RDATA_RST;
      cpu_rd_q <= RDATA_RST;
      mcs_q    <= 1'b0;
      moe_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mdb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      xact_q   <= xact_d;
      ack_q    <= ack_d;
      ppu_rd_q <= ppu_rd_d;
      dma_rd_q <= dma_rd_d;
      cpu_rd_q <= cpu_rd_d;
      mcs_q    <= mcs_d;
      moe_q    <= moe_d;
      mwr_q    <= mwr_d;
      mdb_q    <= mdb_d;
    end
  end

  assign ppu_ack = ack_q[0];
  assign dma_ack = ack_q[1];
  assign cpu_ack = ack_q[2];
  assign ppu_q   = ppu_rd_q;
  assign dma_q   = dma_rd_q;
  assign cpu_q   = cpu_rd_q;
  assign ma      = xact_q.addr;
  assign md_out  = xact_q.wdata;
  assign mcs     = mcs_q;
  assign moe     = moe_q;
  assign mwr     = mwr_q;
  assign md_b    = mdb_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: directed requests, a cycle-schedule model of
// the bus, a VRAM memory behind the port, and hand-computed checkpoints.
module tb_vram_bus_arbiter;

`ifdef VRAM_ARB_CPU_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        reset, ppu_req, dma_req, cpu_req, cpu_wr, cpu_lockout;
  logic [12:0] ppu_a, dma_a, cpu_a, ma;
  logic [7:0]  cpu_d, md_in, md_out, ppu_q, dma_q, cpu_q;
  logic        ppu_ack, dma_ack, cpu_ack, mcs, moe, mwr, md_b;
  logic [1:0]  owner;

  always #5 clk1 = ~clk1;

  vram_bus_arbiter dut (
    .clk1(clk1), .reset(reset),
    .ppu_req(ppu_req), .dma_req(dma_req), .cpu_req(cpu_req),
    .ppu_a(ppu_a), .dma_a(dma_a), .cpu_a(cpu_a),
    .cpu_wr(cpu_wr), .cpu_d(cpu_d), .cpu_lockout(cpu_lockout),
    .ppu_ack(ppu_ack), .dma_ack(dma_ack), .cpu_ack(cpu_ack),
    .ppu_q(ppu_q), .dma_q(dma_q), .cpu_q(cpu_q),
    .ma(ma), .md_out(md_out), .md_in(md_in),
    .mcs(mcs), .moe(moe), .mwr(mwr), .md_b(md_b), .owner(owner)
  );

  // VRAM behind the port: content pattern addr[7:0] ^ A5.
  logic [7:0] env_mem [8192];
  assign md_in = env_mem[ma];
  initial begin
    for (int i = 0; i < 8192; i++) env_mem[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge clk1);
      if (mwr) env_mem[ma] <= md_out;
    end
  end

  // ---------------- model: schedule of bus cycles per grant ----------------
  logic [7:0] ref_mem [8192];
  bit         r_act [8];
  bit         r_wr  [8];
  bit         r_mwr [8];
  logic [1:0] r_own [8];
  logic [2:0] r_ack [8];
  logic [2:0] r_qld [8];
  logic [7:0] r_qv  [8][3];
  logic       e_mcs, e_moe, e_mwr, e_mdb;
  logic [1:0] e_own;
  logic [2:0] e_ack;
  logic [12:0] e_ma;
  logic [7:0] e_mdo;
  logic [7:0] e_q [3];
  int         ecyc, next_edge, excl, w, s0, s1, s2;
  bit [2:0]   elig;
  bit         m_wr;
  logic [12:0] m_a;

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
    ecyc = 0; next_edge = 0; excl = 0;
    forever begin
      @(posedge clk1);
      ecyc = ecyc + 1;
      s0 = ecyc % 8; s1 = (ecyc + 1) % 8; s2 = (ecyc + 2) % 8;
      if (reset) begin
        for (int s = 0; s < 8; s++) begin
          r_act[s] = 0; r_wr[s] = 0; r_mwr[s] = 0; r_own[s] = 2'd0;
          r_ack[s] = 3'b000; r_qld[s] = 3'b000;
        end
        e_mcs = 0; e_moe = 0; e_mwr = 0; e_mdb = 0; e_own = 2'd0; e_ack = 3'b000;
        e_ma = 13'h0; e_mdo = 8'h00;
        for (int p = 0; p < 3; p++) e_q[p] = 8'hFF;
        next_edge = ecyc + 1; excl = 0;
      end else begin
        if (ecyc >= next_edge) begin
          elig = {cpu_req && !(LOCK && cpu_lockout), dma_req, ppu_req};
          if (excl != 0) elig[excl-1] = 1'b0;
          w = 0;
          for (int k = 2; k >= 0; k--) if (elig[k]) w = k + 1;
          if (w != 0) begin
            m_a  = (w == 1) ? ppu_a : (w == 2) ? dma_a : cpu_a;
            m_wr = (w == 3) && cpu_wr;
            e_ma = m_a;
            if (w == 3) e_mdo = cpu_d;
            r_act[s0] = 1; r_wr[s0] = m_wr; r_own[s0] = 2'(w); r_mwr[s0] = 0;
            r_act[s1] = 1; r_wr[s1] = m_wr; r_own[s1] = 2'(w); r_mwr[s1] = m_wr;
            r_ack[s2][w-1] = 1'b1;
            if (m_wr) ref_mem[m_a] = cpu_d;
            else begin
              r_qld[s2][w-1] = 1'b1;
              r_qv[s2][w-1]  = ref_mem[m_a];
            end
            next_edge = ecyc + 2; excl = w;
          end else begin
            next_edge = ecyc + 1; excl = 0;
          end
        end
        if (LOCK && cpu_req && cpu_lockout && e_own != 2'd3 && !e_ack[2]) begin
          r_ack[s0][2] = 1'b1;
          if (!cpu_wr) begin r_qld[s0][2] = 1'b1; r_qv[s0][2] = 8'hFF; end
        end
        e_mcs = r_act[s0];
        e_moe = r_act[s0] && !r_wr[s0];
        e_mwr = r_mwr[s0];
        e_mdb = r_act[s0] && r_wr[s0];
        e_own = r_act[s0] ? r_own[s0] : 2'd0;
        e_ack = r_ack[s0];
        for (int p = 0; p < 3; p++) if (r_qld[s0][p]) e_q[p] = r_qv[s0][p];
        r_act[s0] = 0; r_wr[s0] = 0; r_mwr[s0] = 0; r_own[s0] = 2'd0;
        r_ack[s0] = 3'b000; r_qld[s0] = 3'b000;
      end
    end
  end

  // ---------------- stimulus, per-cycle compare, hand checks ----------------
  int checks = 0, failures = 0;
  bit cmp_en = 0, ppu_hold = 0;
  int pa, da, ca, mc, np;
  int pl [3];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk1);
    if (cmp_en) begin
      cmp("model_strobes_owner_acks",
          32'({mcs, moe, mwr, md_b, owner, ppu_ack, dma_ack, cpu_ack}),
          32'({e_mcs, e_moe, e_mwr, e_mdb, e_own, e_ack[0], e_ack[1], e_ack[2]}));
      cmp("model_ma_mdout", 32'({ma, md_out}), 32'({e_ma, e_mdo}));
      cmp("model_rdata", 32'({ppu_q, dma_q, cpu_q}), 32'({e_q[0], e_q[1], e_q[2]}));
    end
    if (ppu_ack && !ppu_hold) ppu_req = 1'b0;
    if (dma_ack) dma_req = 1'b0;
    if (cpu_ack) cpu_req = 1'b0;
  endtask

  initial begin
    reset = 1; ppu_req = 0; dma_req = 0; cpu_req = 0; cpu_wr = 0; cpu_lockout = 0;
    ppu_a = 13'h0; dma_a = 13'h0; cpu_a = 13'h0; cpu_d = 8'h00;
    step(); step();
    cmp_en = 1;
    step();
    cmp("reset_q", 32'({ppu_q, dma_q, cpu_q}), 32'h00FF_FFFF);
    cmp("reset_bus", 32'({owner, mcs, moe, mwr, md_b, ma, md_out}), 32'h0);
    reset = 0;
    step();

    // CPU write 0123 <= 5A
    cpu_a = 13'h0123; cpu_d = 8'h5A; cpu_wr = 1; cpu_req = 1;
    step();
    cmp("wr_addr_phase", 32'({mcs, moe, mwr, md_b, owner}), 32'({4'b1001, 2'd3}));
    cmp("wr_ma_mdout", 32'({ma, md_out}), 32'({13'h0123, 8'h5A}));
    step();
    cmp("wr_data_phase", 32'({mcs, mwr, md_b}), 32'(3'b111));
    step();
    cmp("wr_ack_e3", 32'({cpu_ack, mcs}), 32'(2'b10));
    step();
    ppu_a = 13'h0123; ppu_req = 1;
    step(); step(); step();
    cmp("rd_back_5a", 32'({ppu_ack, ppu_q}), 32'({1'b1, 8'h5A}));
    step();

    // three simultaneous reads
    ppu_a = 13'h0010; dma_a = 13'h0020; cpu_a = 13'h0030; cpu_wr = 0;
    ppu_req = 1; dma_req = 1; cpu_req = 1;
    pa = 0; da = 0; ca = 0; mc = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ppu_ack) pa = k;
      if (dma_ack) da = k;
      if (cpu_ack) ca = k;
      if (mcs) mc = mc + 1;
    end
    cmp("prio_ack_steps", 32'({8'(pa), 8'(da), 8'(ca)}), 32'h0003_0507);
    cmp("prio_no_idle", 32'(mc), 32'd6);
    cmp("prio_rdata", 32'({ppu_q, dma_q, cpu_q}), 32'h00B5_8595);

    // PPU held alone: one access per 3 cycles
    ppu_a = 13'h0040; ppu_hold = 1; ppu_req = 1; np = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (ppu_ack && np < 3) begin pl[np] = k; np = np + 1; end
    end
    cmp("ppu_repeat_steps", 32'({8'(np), 8'(pl[0]), 8'(pl[1]), 8'(pl[2])}), 32'h0303_0609);
    ppu_hold = 0;
    repeat (6) step();

    // PPU held with CPU waiting: CPU slots into the back-to-back gap
    ppu_a = 13'h0040; cpu_a = 13'h0050; cpu_wr = 0;
    ppu_hold = 1; ppu_req = 1; cpu_req = 1; np = 0; ca = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ppu_ack && np < 3) begin pl[np] = k; np = np + 1; end
      if (cpu_ack) ca = k;
    end
    cmp("ppu_cpu_mix", 32'({8'(pl[0]), 8'(ca), 8'(pl[1]), 8'(pl[2])}), 32'h0305_070A);
    cmp("ppu_cpu_rdata", 32'({ppu_q, cpu_q}), 32'h0000_E5F5);
    ppu_hold = 0;
    repeat (6) step();

    // CPU under lockout
    cpu_lockout = 1; cpu_a = 13'h1FFF; cpu_wr = 0; cpu_req = 1;
    step();
    if (LOCK) begin
      cmp("lock_rd_ack", 32'({cpu_ack, mcs, cpu_q}), 32'({2'b10, 8'hFF}));
      step();
    end else begin
      cmp("nolock_rd_grant", 32'({mcs, owner}), 32'({1'b1, 2'd3}));
      step(); step();
      cmp("nolock_rd_ack", 32'({cpu_ack, cpu_q}), 32'({1'b1, 8'h5A}));
    end
    step();
    cpu_a = 13'h0123; cpu_d = 8'h33; cpu_wr = 1; cpu_req = 1;
    step();
    if (LOCK) begin
      cmp("lock_wr_ack", 32'({cpu_ack, mcs}), 32'(2'b10));
    end else begin
      step(); step();
      cmp("nolock_wr_ack", 32'(cpu_ack), 32'd1);
    end
    step(); step();
    cpu_lockout = 0; ppu_a = 13'h0123; ppu_req = 1;
    step(); step(); step();
    cmp("lock_wr_effect", 32'({ppu_ack, ppu_q}), 32'({1'b1, LOCK ? 8'h5A : 8'h33}));
    step();

    // reset during DATA of a DMA read
    dma_a = 13'h0020; dma_req = 1; cpu_wr = 0;
    step(); step();
    cmp("dma_in_data", 32'({mcs, mwr, owner}), 32'({2'b10, 2'd2}));
    reset = 1;
    step();
    cmp("rst_abort", 32'({dma_ack, mcs, moe, md_b, owner, dma_q}), 32'({4'b0000, 2'd0, 8'hFF}));
    reset = 0;
    step(); step(); step();
    cmp("dma_reissue", 32'({dma_ack, dma_q}), 32'({1'b1, 8'h85}));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
